// File: rtl/dm_copy_engine.sv
// Word copy engine: copies len 32-bit words from byte address src to dst through the data-memory port.
// Optional DM_COPY_FILL_EN adds a fill mode that writes fill_val to the dst range without reading.
module dm_copy_engine #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DM_BYTES = 12288,
    parameter int unsigned LEN_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
`ifdef DM_COPY_FILL_EN
    input  logic              fill,
    input  logic [31:0]       fill_val,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    localparam int unsigned CHK_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sa_q, sa_d;
    logic [ADDR_W-1:0]   da_q, da_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         buf_q, buf_d;
    logic                err_q, err_d;
    logic                fill_q, fill_d;

    logic                req_fill_c;
    logic [31:0]         fill_word_c;
    logic [CHK_W-1:0]    src_end_c;
    logic [CHK_W-1:0]    dst_end_c;
    logic                range_err_c;

`ifdef DM_COPY_FILL_EN
    assign req_fill_c  = fill;
    assign fill_word_c = fill_val;
`else
    assign req_fill_c  = 1'b0;
    assign fill_word_c = 32'h0;
`endif

    // End-of-range check in 16 bits so that no operand combination can wrap.
    always_comb begin
        src_end_c   = CHK_W'(src) + (CHK_W'(len) << 2);
        dst_end_c   = CHK_W'(dst) + (CHK_W'(len) << 2);
        range_err_c = (dst_end_c > CHK_W'(DM_BYTES))
                    | ((src_end_c > CHK_W'(DM_BYTES)) & ~req_fill_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            da_q    <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            da_q    <= da_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        da_d    = da_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        fill_d  = fill_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d   = src;
                    da_d   = dst;
                    cnt_d  = len;
                    fill_d = req_fill_c;
                    err_d  = range_err_c;
                    buf_d  = req_fill_c ? fill_word_c : 32'h0;
                    if (range_err_c || (len == '0)) begin
                        state_d = S_DONE;
                    end else if (req_fill_c) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                buf_d   = dm_dout;
                sa_d    = sa_q + ADDR_W'(4);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                da_d  = da_q + ADDR_W'(4);
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end else if (fill_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port outputs are decoded from the state register; the write strobe is also gated by reset.
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        err     = (state_q == S_DONE) & err_q;
        dm_we   = (state_q == S_WRITE) & rst_n;
        dm_addr = '0;
        dm_din  = 32'h0;
        if (state_q == S_READ) begin
            dm_addr = sa_q;
        end else if (state_q == S_WRITE) begin
            dm_addr = da_q;
            dm_din  = buf_q;
        end
    end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Directed bench for dm_copy_engine with a byte-addressed memory model (little-endian words).
module tb_dm_copy_engine;

    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned DM_BYTES = 12288;
    localparam int unsigned LEN_W    = 12;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
`ifdef DM_COPY_FILL_EN
    logic              fill;
    logic [31:0]       fill_val;
`endif
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic [31:0]       dm_dout;

    logic [7:0] mem [0:DM_BYTES-1];
    int n_cmp;
    int n_bad;
    int we_count;
    int done_count;

    dm_copy_engine #(.ADDR_W(ADDR_W), .DM_BYTES(DM_BYTES), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
`ifdef DM_COPY_FILL_EN
        .fill(fill), .fill_val(fill_val),
`endif
        .busy(busy), .done(done), .err(err), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_we(dm_we), .dm_dout(dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (int'(dm_addr) + 3 < int'(DM_BYTES))
            dm_dout = {mem[int'(dm_addr)+3], mem[int'(dm_addr)+2], mem[int'(dm_addr)+1], mem[int'(dm_addr)]};
        else
            dm_dout = 32'h0;
    end

    always @(posedge clk) begin
        if (dm_we && (int'(dm_addr) + 3 < int'(DM_BYTES))) begin
            for (int i = 0; i < 4; i++) mem[int'(dm_addr)+i] <= dm_din[8*i +: 8];
        end
        if (dm_we) we_count <= we_count + 1;
        if (done) done_count <= done_count + 1;
    end

    function automatic logic [31:0] rd(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic wr(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a+i] <= w[8*i +: 8];
    endtask

    // Start is driven for one cycle; returns at the negedge after the accepting edge (latency 1).
    task automatic start_op(input int s, input int d, input int l, input logic f, input logic [31:0] fv);
        src   = ADDR_W'(s);
        dst   = ADDR_W'(d);
        len   = LEN_W'(l);
`ifdef DM_COPY_FILL_EN
        fill     = f;
        fill_val = fv;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (f && (fv == 32'h1)) start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bo);
        lat = 1;
        bo  = 0;
        while (!done && lat < 200) begin
            if (busy) bo++;
            @(negedge clk);
            lat++;
        end
        if (!done) $display("FAIL wait_done: no done pulse within %0d cycles", lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        src = '0; dst = '0; len = '0;
`ifdef DM_COPY_FILL_EN
        fill = 1'b0; fill_val = 32'h0;
`endif
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, err, dm_we} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, dm_we}); end
        n_cmp++; if (dm_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", dm_addr); end
        n_cmp++; if (dm_din !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h want 0", dm_din); end
        rst_n = 1'b1;
        we_count = 0;
        done_count = 0;
        @(negedge clk);
    endtask

    task automatic test_copy();
        int lat, bo, we0;
        for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
        for (int i = 64; i < 80; i++) mem[i] <= 8'hFF;
        @(negedge clk);
        we0 = we_count;
        start_op(0, 64, 4, 1'b0, 32'h0);
        n_cmp++; if (dm_addr !== ADDR_W'(0) || dm_we !== 1'b0) begin n_bad++; $display("FAIL copy_first_read: addr %h we %b want 0/0", dm_addr, dm_we); end
        wait_done(lat, bo);
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL copy_latency: got %0d want 9", lat); end
        n_cmp++; if (bo != 8) begin n_bad++; $display("FAIL copy_busy_cycles: got %0d want 8", bo); end
        n_cmp++; if ({busy, err} !== 2'b10) begin n_bad++; $display("FAIL copy_done_flags: busy/err %b want 10", {busy, err}); end
        @(negedge clk);
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL copy_idle: busy/done %b want 00", {busy, done}); end
        n_cmp++; if (rd(64) !== 32'h03020100) begin n_bad++; $display("FAIL copy_w0: got %h want 03020100", rd(64)); end
        n_cmp++; if (rd(68) !== 32'h07060504) begin n_bad++; $display("FAIL copy_w1: got %h want 07060504", rd(68)); end
        n_cmp++; if (rd(72) !== 32'h0B0A0908) begin n_bad++; $display("FAIL copy_w2: got %h want 0B0A0908", rd(72)); end
        n_cmp++; if (rd(76) !== 32'h0F0E0D0C) begin n_bad++; $display("FAIL copy_w3: got %h want 0F0E0D0C", rd(76)); end
        n_cmp++; if (we_count - we0 != 4) begin n_bad++; $display("FAIL copy_writes: got %0d want 4", we_count - we0); end
    endtask

    task automatic test_len0();
        int lat, bo, we0;
        we0 = we_count;
        start_op(100, 200, 0, 1'b0, 32'h0);
        wait_done(lat, bo);
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL len0_latency: got %0d want 1", lat); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL len0_err: got %b want 0", err); end
        @(negedge clk);
        n_cmp++; if (we_count - we0 != 0) begin n_bad++; $display("FAIL len0_writes: got %0d want 0", we_count - we0); end
    endtask

    task automatic test_range();
        int lat, bo, we0;
        wr(12284, 32'hDDCCBBAA);
        wr(200, 32'h0);
        @(negedge clk);
        start_op(12284, 200, 1, 1'b0, 32'h0);
        wait_done(lat, bo);
        n_cmp++; if (lat != 3 || err !== 1'b0) begin n_bad++; $display("FAIL range_last_word: lat %0d err %b want 3/0", lat, err); end
        @(negedge clk);
        n_cmp++; if (rd(200) !== 32'hDDCCBBAA) begin n_bad++; $display("FAIL range_last_data: got %h want DDCCBBAA", rd(200)); end
        we0 = we_count;
        start_op(12285, 300, 1, 1'b0, 32'h0);
        wait_done(lat, bo);
        n_cmp++; if (lat != 1 || err !== 1'b1) begin n_bad++; $display("FAIL range_src_err: lat %0d err %b want 1/1", lat, err); end
        @(negedge clk);
        n_cmp++; if (we_count - we0 != 0) begin n_bad++; $display("FAIL range_src_nowrite: got %0d want 0", we_count - we0); end
        start_op(0, 12000, 100, 1'b0, 32'h0);
        wait_done(lat, bo);
        n_cmp++; if (lat != 1 || err !== 1'b1) begin n_bad++; $display("FAIL range_dst_err: lat %0d err %b want 1/1", lat, err); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL range_err_pulse: got %b want 0", err); end
    endtask

    task automatic test_overlap();
        int lat, bo;
        wr(0, 32'hA1A2A3A4);
        wr(4, 32'hB1B2B3B4);
        wr(8, 32'h0);
        @(negedge clk);
        start_op(0, 4, 2, 1'b0, 32'h0);
        wait_done(lat, bo);
        @(negedge clk);
        n_cmp++; if (rd(4) !== 32'hA1A2A3A4) begin n_bad++; $display("FAIL overlap_w4: got %h want A1A2A3A4", rd(4)); end
        n_cmp++; if (rd(8) !== 32'hA1A2A3A4) begin n_bad++; $display("FAIL overlap_w8: got %h want A1A2A3A4", rd(8)); end
    endtask

    task automatic test_reset_mid();
        int we0, dn0;
        for (int i = 0; i < 32; i++) mem[i] <= 8'(i + 'h40);
        for (int i = 512; i < 544; i++) mem[i] <= 8'hFF;
        @(negedge clk);
        we0 = we_count;
        dn0 = done_count;
        start_op(0, 512, 8, 1'b0, 32'h0);
        repeat (5) @(negedge clk);
        n_cmp++; if (dm_we !== 1'b1 || dm_addr !== ADDR_W'(520)) begin n_bad++; $display("FAIL rstmid_third_write: we %b addr %0d want 1/520", dm_we, dm_addr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dm_we !== 1'b0) begin n_bad++; $display("FAIL rstmid_we_gated: got %b want 0", dm_we); end
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL rstmid_idle: busy/done %b want 00", {busy, done}); end
        repeat (4) @(negedge clk);
        n_cmp++; if (we_count - we0 != 2) begin n_bad++; $display("FAIL rstmid_writes: got %0d want 2", we_count - we0); end
        n_cmp++; if (done_count - dn0 != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_count - dn0); end
        n_cmp++; if (rd(512) !== 32'h43424140 || rd(516) !== 32'h47464544) begin n_bad++; $display("FAIL rstmid_data: got %h %h want 43424140 47464544", rd(512), rd(516)); end
        n_cmp++; if (rd(520) !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL rstmid_untouched: got %h want FFFFFFFF", rd(520)); end
    endtask

    task automatic test_back_to_back();
        int lat, bo, dn0;
        for (int i = 1024; i < 1040; i++) mem[i] <= 8'h00;
        wr(2048, 32'h5A5A5A5A);
        @(negedge clk);
        dn0 = done_count;
        start_op(0, 1024, 3, 1'b0, 32'h0);
        @(negedge clk);
        start_op(16, 2048, 1, 1'b0, 32'h0);
        wait_done(lat, bo);
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL busy_start_latency: got %0d cycles after second start, want 5", lat); end
        repeat (6) @(negedge clk);
        n_cmp++; if (done_count - dn0 != 1) begin n_bad++; $display("FAIL busy_start_done_count: got %0d want 1", done_count - dn0); end
        n_cmp++; if (rd(1024) !== 32'h43424140 || rd(1032) !== 32'h4B4A4948) begin n_bad++; $display("FAIL busy_start_data: got %h %h want 43424140 4B4A4948", rd(1024), rd(1032)); end
        n_cmp++; if (rd(2048) !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL busy_start_ignored: got %h want 5A5A5A5A", rd(2048)); end
    endtask

`ifdef DM_COPY_FILL_EN
    task automatic test_fill();
        int lat, bo, we0;
        for (int i = 128; i < 144; i++) mem[i] <= 8'h00;
        @(negedge clk);
        we0 = we_count;
        start_op(12285, 128, 3, 1'b1, 32'hDEADBEEF);
        wait_done(lat, bo);
        n_cmp++; if (lat != 4 || err !== 1'b0) begin n_bad++; $display("FAIL fill_latency: lat %0d err %b want 4/0", lat, err); end
        @(negedge clk);
        fill = 1'b0;
        n_cmp++; if (we_count - we0 != 3) begin n_bad++; $display("FAIL fill_writes: got %0d want 3", we_count - we0); end
        n_cmp++; if (rd(128) !== 32'hDEADBEEF || rd(136) !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fill_data: got %h %h want DEADBEEF", rd(128), rd(136)); end
        n_cmp++; if (rd(140) !== 32'h0) begin n_bad++; $display("FAIL fill_bound: got %h want 0", rd(140)); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        we_count = 0;
        done_count = 0;
        test_reset();
        test_copy();
        test_len0();
        test_range();
        test_overlap();
        test_reset_mid();
        test_back_to_back();
`ifdef DM_COPY_FILL_EN
        test_fill();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
